// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  localparam int         WB_CTI_W = 3;
  localparam int         WB_BTE_W = 2;
  localparam logic [2:0] CTI_END  = 3'b111;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_pick #(
  parameter int MASTERS = 4,
  parameter int IDX_W   = 2
) (
  input  logic [MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Scan from the farthest candidate down to ptr so the nearest requester wins.
  always_comb begin
    int c;
    c       = 0;
    o_valid = |i_req;
    o_idx   = i_ptr;
    for (int k = MASTERS - 1; k >= 0; k--) begin
      c = int'(i_ptr) + k;
      if (c >= MASTERS) c = c - MASTERS;
      if (i_req[c]) o_idx = IDX_W'(c);
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B3 arbiter: one slave port shared by MASTERS masters,
// grant held for a whole bus cycle, watchdog aborts unanswered strobes.
module wb_arbiter_rr
  import wb_pkg::*;
#(
  parameter int MASTERS    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [ADDR_WIDTH*MASTERS-1:0]      m_adr_i,
  input  logic [DATA_WIDTH*MASTERS-1:0]      m_dat_i,
  input  logic [MASTERS-1:0]                 m_cyc_i,
  input  logic [MASTERS-1:0]                 m_stb_i,
  input  logic [(DATA_WIDTH/8)*MASTERS-1:0]  m_sel_i,
  input  logic [MASTERS-1:0]                 m_we_i,
  input  logic [WB_CTI_W*MASTERS-1:0]        m_cti_i,
  input  logic [WB_BTE_W*MASTERS-1:0]        m_bte_i,
  output logic [DATA_WIDTH*MASTERS-1:0]      m_dat_o,
  output logic [MASTERS-1:0]                 m_ack_o,
  output logic [MASTERS-1:0]                 m_err_o,
  output logic [MASTERS-1:0]                 m_rty_o,
  output logic [ADDR_WIDTH-1:0]              s_adr_o,
  output logic [DATA_WIDTH-1:0]              s_dat_o,
  output logic [DATA_WIDTH/8-1:0]            s_sel_o,
  output logic                               s_we_o,
  output logic [WB_CTI_W-1:0]                s_cti_o,
  output logic [WB_BTE_W-1:0]                s_bte_o,
  output logic                               s_cyc_o,
  output logic                               s_stb_o,
  input  logic [DATA_WIDTH-1:0]              s_dat_i,
  input  logic                               s_ack_i,
  input  logic                               s_err_i,
  input  logic                               s_rty_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W     = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  arb_state_t         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_gnt_idx, w_gnt_nxt;
  logic [IDX_W-1:0]   w_rr_ptr;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_vld;
  logic               w_ptr_load;
  logic               w_wdog_hit;
  logic               w_cyc_g, w_stb_g;
  logic [MASTERS-1:0] w_gnt_oh;

  rr_pick #(
    .MASTERS (MASTERS),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (m_cyc_i),
    .i_ptr   (w_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  // Route the granted master's request fields to the slave side (master 0 by default).
  always_comb begin
    s_adr_o  = m_adr_i[ADDR_WIDTH-1:0];
    s_dat_o  = m_dat_i[DATA_WIDTH-1:0];
    s_sel_o  = m_sel_i[SEL_WIDTH-1:0];
    s_we_o   = m_we_i[0];
    s_cti_o  = m_cti_i[WB_CTI_W-1:0];
    s_bte_o  = m_bte_i[WB_BTE_W-1:0];
    w_cyc_g  = m_cyc_i[0];
    w_stb_g  = m_stb_i[0];
    w_gnt_oh = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (r_gnt_idx == IDX_W'(i)) begin
        s_adr_o     = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o     = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o     = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
        s_we_o      = m_we_i[i];
        s_cti_o     = m_cti_i[i*WB_CTI_W +: WB_CTI_W];
        s_bte_o     = m_bte_i[i*WB_BTE_W +: WB_BTE_W];
        w_cyc_g     = m_cyc_i[i];
        w_stb_g     = m_stb_i[i];
        w_gnt_oh[i] = 1'b1;
      end
    end
  end

  // Read data is broadcast; only the granted master sees an ack.
  assign m_dat_o = {MASTERS{s_dat_i}};

  // Next-state and bus-control outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_idx;
    w_ptr_load  = 1'b0;
    s_cyc_o     = 1'b0;
    s_stb_o     = 1'b0;
    m_ack_o     = '0;
    m_err_o     = '0;
    m_rty_o     = '0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_gnt_nxt   = w_pick_idx;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        s_cyc_o = w_cyc_g;
        s_stb_o = w_cyc_g & w_stb_g;
        m_ack_o = w_gnt_oh & {MASTERS{s_ack_i}};
        m_err_o = w_gnt_oh & {MASTERS{s_err_i}};
        m_rty_o = w_gnt_oh & {MASTERS{s_rty_i}};
        if (!w_cyc_g) begin
          w_ptr_load  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_wdog_hit) begin
          w_state_nxt = ABORT;
        end
      end
      ABORT: begin
        m_err_o     = w_gnt_oh;
        w_state_nxt = GRANT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_gnt_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt_idx <= w_gnt_nxt;
    end
  end

  generate
    if (MASTERS > 1) begin : g_ptr
      logic [IDX_W-1:0] r_rr_ptr;
      // Pointer moves just past the master whose cycle ended.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)         r_rr_ptr <= '0;
        else if (w_ptr_load) r_rr_ptr <= (r_gnt_idx == IDX_W'(MASTERS - 1)) ? '0 : r_gnt_idx + 1'b1;
      end
      assign w_rr_ptr = r_rr_ptr;
    end else begin : g_no_ptr
      assign w_rr_ptr = '0;
    end

    if (TIMEOUT > 0) begin : g_wdog
      localparam int WD_W = $clog2(TIMEOUT + 1);
      logic [WD_W-1:0] r_wdog;
      logic            w_wdog_inc;
      assign w_wdog_inc = (r_state == GRANT) && s_stb_o && !(s_ack_i || s_err_i || s_rty_i);
      assign w_wdog_hit = w_wdog_inc && (r_wdog == WD_W'(TIMEOUT - 1));
      // Count consecutive unanswered strobe cycles; anything else clears.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)         r_wdog <= '0;
        else if (w_wdog_inc) r_wdog <= r_wdog + 1'b1;
        else                 r_wdog <= '0;
      end
    end else begin : g_no_wdog
      assign w_wdog_hit = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr (4 masters, 16-cycle watchdog).
module tb_wb_arbiter_rr;
  import wb_pkg::*;

  localparam int M  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  localparam logic [AW-1:0] A0 = 32'h1000_0000;
  localparam logic [AW-1:0] A1 = 32'h1000_0100;
  localparam logic [AW-1:0] A2 = 32'h1000_0200;
  localparam logic [AW-1:0] A3 = 32'h1000_0300;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [AW*M-1:0]   m_adr_i;
  logic [DW*M-1:0]   m_dat_i;
  logic [M-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [DW/8*M-1:0] m_sel_i;
  logic [3*M-1:0]    m_cti_i;
  logic [2*M-1:0]    m_bte_i;
  logic [DW*M-1:0]   m_dat_o;
  logic [M-1:0]      m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o, s_dat_i;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic              s_ack_i, s_err_i, s_rty_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  wb_arbiter_rr #(
    .MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    m_adr_i = {A3, A2, A1, A0};
    m_dat_i = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
    m_sel_i = 16'h8421;
    m_we_i  = 4'b0101;
    m_cti_i = '0;
    m_bte_i = '0;
    s_dat_i = 32'hCAFE_F00D;

    // Reset with all masters requesting and the slave (wrongly) responding.
    rst_ni  = 1'b0;
    m_cyc_i = 4'b1111;
    m_stb_i = 4'b1111;
    s_ack_i = 1'b1; s_err_i = 1'b1; s_rty_i = 1'b1;
    #3;
    chk_eq("rst_cyc", s_cyc_o, 0);
    chk_eq("rst_stb", s_stb_o, 0);
    chk_eq("rst_ack", m_ack_o, 0);
    chk_eq("rst_err", m_err_o, 0);
    chk_eq("rst_rty", m_rty_o, 0);
    chk_eq("rst_adr_m0", s_adr_o, A0);
    step(); step();
    chk_eq("rst_hold_cyc", s_cyc_o, 0);
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    rst_ni  = 1'b1;

    // 1: grants 0,1,2,3 in turn, one IDLE cycle between each.
    for (int i = 0; i < M; i++) begin
      step();
      chk_eq($sformatf("t1_adr_%0d", i), s_adr_o, m_adr_i[i*AW +: AW]);
      chk_eq($sformatf("t1_cyc_%0d", i), s_cyc_o, 1);
      chk_eq($sformatf("t1_sel_%0d", i), s_sel_o, m_sel_i[i*4 +: 4]);
      m_cyc_i[i] = 1'b0;
      m_stb_i[i] = 1'b0;
      step();
      chk_eq($sformatf("t1_idle_%0d", i), s_cyc_o, 0);
    end
    chk_eq("t1_rdata_bcast", m_dat_o, {4{32'hCAFE_F00D}});
    step();

    // 2: masters 0 and 2 request; master 0 runs a 4-beat burst.
    m_cyc_i = 4'b0101;
    m_stb_i = 4'b0101;
    step();
    chk_eq("t2_adr_m0", s_adr_o, A0);
    chk_eq("t2_wdat_m0", s_dat_o, 32'hDDDD_0000);
    for (int b = 0; b < 4; b++) begin
      m_cti_i[2:0] = (b == 3) ? CTI_END : 3'b010;
      s_ack_i = 1'b1;
      if (b == 3) begin
        m_cyc_i[0] = 1'b0;
        m_stb_i[0] = 1'b0;
      end
      #1;
      chk_eq($sformatf("t2_ack_b%0d", b), m_ack_o, 4'b0001);
      chk_eq($sformatf("t2_cti_b%0d", b), s_cti_o, (b == 3) ? 3'b111 : 3'b010);
      step();
    end
    s_ack_i = 1'b0;
    #1;
    chk_eq("t2_idle_cyc", s_cyc_o, 0);
    step();
    chk_eq("t2_adr_m2", s_adr_o, A2);
    chk_eq("t2_cyc_m2", s_cyc_o, 1);

    // 5: err/rty routed only to the granted master, grant unchanged.
    s_err_i = 1'b1;
    #1;
    chk_eq("t5_err", m_err_o, 4'b0100);
    chk_eq("t5_err_rty", m_rty_o, 0);
    step();
    s_err_i = 1'b0;
    s_rty_i = 1'b1;
    #1;
    chk_eq("t5_rty", m_rty_o, 4'b0100);
    chk_eq("t5_rty_err", m_err_o, 0);
    chk_eq("t5_still_m2", s_adr_o, A2);
    step();
    s_rty_i = 1'b0;
    #1;
    chk_eq("t5_cyc_kept", s_cyc_o, 1);
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    step();

    // 3: master 1 holds, master 3 arrives; master 3 goes before master 1 again.
    m_cyc_i = 4'b0010;
    m_stb_i = 4'b0010;
    step();
    chk_eq("t3_adr_m1", s_adr_o, A1);
    m_cyc_i = 4'b1010;
    m_stb_i = 4'b1010;
    step();
    chk_eq("t3_hold_m1", s_adr_o, A1);
    step();
    m_cyc_i = 4'b1000;
    m_stb_i = 4'b1000;
    step();
    m_cyc_i = 4'b1010;
    m_stb_i = 4'b1010;
    #1;
    chk_eq("t3_idle_cyc", s_cyc_o, 0);
    step();
    chk_eq("t3_adr_m3", s_adr_o, A3);
    m_cyc_i = 4'b0010;
    m_stb_i = 4'b0010;
    step();
    step();
    chk_eq("t3_adr_m1_again", s_adr_o, A1);

    // 4: slave never answers master 1 -> abort after 16 strobe cycles.
    cnt = 0;
    while (s_stb_o && cnt < 100) begin
      cnt++;
      step();
    end
    chk_eq("t4_stb_len", cnt, TO);
    chk_eq("t4_abort_cyc", s_cyc_o, 0);
    chk_eq("t4_abort_err", m_err_o, 4'b0010);
    step();
    chk_eq("t4_regrant_stb", s_stb_o, 1);
    chk_eq("t4_regrant_err", m_err_o, 0);
    cnt = 0;
    while (s_stb_o && cnt < 100) begin
      cnt++;
      step();
    end
    chk_eq("t4_stb_len2", cnt, TO);
    m_cyc_i = 4'b0000;
    m_stb_i = 4'b0000;
    step(); step(); step();

    // 6: async reset mid-burst, arbitration restarts at master 0.
    m_cyc_i = 4'b0001;
    m_stb_i = 4'b0001;
    step();
    s_ack_i = 1'b1;
    #1;
    chk_eq("t6_ack_m0", m_ack_o, 4'b0001);
    step();
    m_cyc_i = 4'b1111;
    m_stb_i = 4'b1111;
    #1;
    rst_ni = 1'b0;
    #1;
    chk_eq("t6_async_cyc", s_cyc_o, 0);
    chk_eq("t6_async_stb", s_stb_o, 0);
    chk_eq("t6_async_ack", m_ack_o, 0);
    s_ack_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    chk_eq("t6_restart_m0", s_adr_o, A0);
    chk_eq("t6_restart_cyc", s_cyc_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
